tlb_unit: RTL and testbench
===========================

# tlb_unit

Joint TLB for the MIPS core: 16 fully-associative entries. It serves two translation ports (instruction fetch, data access) plus the TLBP probe, TLBR read and TLBWI write paths driven by the CP0 register block. Entry contents are written and read in the same 78-bit packed format that CP0 produces and consumes. All results are registered, giving one-cycle latency; the pipeline front end and memory stage sit upstream and downstream of it.

## Interface
- TLBNUM, 16, number of entries; power of two, index width IW = $clog2(TLBNUM)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high (fixed)
- cur_asid  in  8  current ASID, taken from EntryHi[7:0]
- s0_req  in  1  fetch translation request
- s0_vaddr  in  32  fetch virtual address
- s0_valid  out  1  fetch result valid; one-cycle pulse
- s0_paddr  out  32  physical address
- s0_uncached  out  1  1 when kseg1, or mapped with C != 3
- s0_refill  out  1  no matching entry
- s0_invalid  out  1  matched, but V = 0
- s1_req / s1_vaddr / s1_store  in  1/32/1  data translation request; store flag
- s1_valid / s1_paddr / s1_uncached / s1_refill / s1_invalid  out  data-port results, same meaning as s0
- s1_modified  out  1  store to a matched, valid page with D = 0
- p_req  in  1  TLBP request
- p_entryhi  in  32  EntryHi to probe
- p_valid  out  1  probe done pulse
- p_index  out  32  bit31 = P (1 = miss); [IW-1:0] = hit index; other bits 0
- r_req  in  1  TLBR request
- r_index  in  IW  entry to read
- r_valid  out  1  read done pulse; drives CP0 tlbr_wen
- r_entry  out  78  packed entry
- w_en  in  1  TLBWI strobe
- w_index  in  IW  target entry
- w_entry  in  78  packed entry from CP0

## Operation
- Packed entry layout:
  - [77:59] VPN2
  - [58:51] ASID
  - [50] G
  - [49:25] lo0 = {PFN[19:0], C[2:0], D, V}
  - [24:0] lo1, same sub-layout
- Match condition for entry i: VPN2 == vaddr[31:13], and (G or ASID == cur_asid). For probe, the ASID compared is p_entryhi[7:0].
- Page select: vaddr[12]; 0 selects lo0, 1 selects lo1.
- Translation result: paddr = {PFN, vaddr[11:0]}.
- Multiple matches: the lowest index wins. This is deterministic; software is responsible for avoiding duplicates.
- Unmapped segments bypass the TLB, and refill/invalid/modified stay 0:
  - vaddr[31:29] = 3'b100 (kseg0): paddr = {3'b000, vaddr[28:0]}, uncached = 0
  - vaddr[31:29] = 3'b101 (kseg1): paddr = {3'b000, vaddr[28:0]}, uncached = 1
- Mapped flags:
  - refill = no match
  - invalid = match and V = 0
  - modified = s1_store and match and V = 1 and D = 0
  - The flags are mutually exclusive.
  - When any flag is set, paddr is don't-care but must be driven as 0.
- Probe:
  - hit: p_index = {1'b0, zeros, hit index}
  - miss: p_index = 32'h8000_0000
- Write: the entry at w_index is replaced wholesale on the clock edge where w_en = 1.
- Reset clears every entry to all-zeros, so every V = 0 and G = 0.

## Timing
- All ports accept a request every cycle and are fully pipelined; there is no backpressure.
- A request sampled at edge N yields its *_valid and result at N+1. *_valid is high for exactly one cycle per request.
- Results hold their value until the next valid pulse on the same port.
- Write/lookup collision: a w_en at edge N is not visible to requests sampled at N, which see old contents. It is visible to requests sampled at N+1 onward. The same rule applies to TLBR and TLBP.
- Reset values:
  - all *_valid = 0
  - s*_paddr, p_index, r_entry = 0
  - all flags = 0
- Reset asserted mid-request: the pending result is discarded; no valid pulse follows reset.
- Concurrency: s0, s1, p, r and w may all be active in the same cycle; each is independent.

## Structure
- Shared package tlb_pkg holds:
  - field offsets and widths of the 78-bit entry (VPN2_HI/LO, ASID_HI/LO, G_BIT, LO0_HI/LO, LO1_HI/LO)
  - segment constants KSEG0 = 3'b100 and KSEG1 = 3'b101
  - C_CACHED = 3
- One sub-module, tlb_match: a combinational comparator over all entries.
  - inputs: vpn2, asid, entry array
  - outputs: hit, lowest index, and selected lo half
  - instantiated three times (s0, s1, probe)
- tlb_unit holds the entry storage, segment bypass, flag logic and output registers.

## Test plan
- Reset, then s0_req with vaddr 0x0040_0000 → at N+1: s0_valid = 1, s0_refill = 1, s0_paddr = 0.
- w_en at index 3 with VPN2 = 0x00200, ASID = 0x05, G = 0, lo0 = {PFN 0x01234, C = 3, D = 1, V = 1}; cur_asid = 5; s1_req vaddr 0x0040_0ABC → s1_paddr = 0x0123_4ABC, uncached = 0, no flags.
- Same entry, cur_asid = 6 → refill. Set G = 1 via rewrite → hit. lo1 with V = 0 and vaddr 0x0040_1000 → s1_invalid = 1.
- Store through a lo0 entry with D = 0 → s1_modified = 1. Load to the same address → no flags.
- s0 vaddr 0xA000_1234 → paddr 0x0000_1234, uncached = 1. s0 vaddr 0x8000_1234 → paddr 0x0000_1234, uncached = 0.
- Same-cycle w_en index 3 plus p_req for that VPN2 on an empty TLB → p_index = 0x8000_0000. p_req one cycle later → p_index = 3. r_req index 3 → r_entry equals the written w_entry.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the joint TLB: packed entry layout, segment codes and
// the per-port translation result with its bypass/flag resolution.
package tlb_pkg;

  localparam int ENTRY_W = 78;
  localparam int VPN2_HI = 77;
  localparam int VPN2_LO = 59;
  localparam int ASID_HI = 58;
  localparam int ASID_LO = 51;
  localparam int G_BIT   = 50;
  localparam int LO0_HI  = 49;
  localparam int LO0_LO  = 25;
  localparam int LO1_HI  = 24;
  localparam int LO1_LO  = 0;
  localparam int LO_W    = 25;

  // Fields inside one lo half: {PFN[19:0], C[2:0], D, V}
  localparam int PFN_HI = 24;
  localparam int PFN_LO = 5;
  localparam int C_HI   = 4;
  localparam int C_LO   = 2;
  localparam int D_BIT  = 1;
  localparam int V_BIT  = 0;

  localparam logic [2:0] KSEG0    = 3'b100;
  localparam logic [2:0] KSEG1    = 3'b101;
  localparam logic [2:0] C_CACHED = 3'd3;

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        refill;
    logic        invalid;
    logic        modified;
  } xlat_t;

  // Unmapped segments win over the lookup; flags are mutually exclusive and
  // force paddr to 0 so a faulting access never leaks a stale frame number.
  function automatic xlat_t translate(input logic [31:0]     vaddr,
                                      input logic            hit,
                                      input logic [LO_W-1:0] lo,
                                      input logic            store);
    xlat_t r;
    r = '0;
    if (vaddr[31:29] == KSEG0 || vaddr[31:29] == KSEG1) begin
      r.paddr    = {3'b000, vaddr[28:0]};
      r.uncached = (vaddr[31:29] == KSEG1);
    end else if (!hit) begin
      r.refill = 1'b1;
    end else begin
      r.uncached = (lo[C_HI:C_LO] != C_CACHED);
      if (!lo[V_BIT]) begin
        r.invalid = 1'b1;
      end else if (store && !lo[D_BIT]) begin
        r.modified = 1'b1;
      end else begin
        r.paddr = {lo[PFN_HI:PFN_LO], vaddr[11:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational fully-associative comparator: reports hit, the lowest matching
// index and the lo half picked by the page-select bit.
module tlb_match
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic [18:0]                      vpn2_i,
  input  logic [7:0]                       asid_i,
  input  logic                             odd_i,
  input  logic [TLBNUM-1:0][ENTRY_W-1:0]   entries_i,
  output logic                             hit_o,
  output logic [IW-1:0]                    index_o,
  output logic [LO_W-1:0]                  lo_o
);

  // Scan from the top so the last assignment, i.e. the lowest index, sticks.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    lo_o    = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (entries_i[i][VPN2_HI:VPN2_LO] == vpn2_i &&
          (entries_i[i][G_BIT] || entries_i[i][ASID_HI:ASID_LO] == asid_i)) begin
        hit_o   = 1'b1;
        index_o = IW'(i);
        lo_o    = odd_i ? entries_i[i][LO1_HI:LO1_LO] : entries_i[i][LO0_HI:LO0_LO];
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// Joint 16-entry TLB: two translation ports, TLBP probe, TLBR read and TLBWI
// write, all results registered with one-cycle latency.
module tlb_unit
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           cur_asid,

  input  logic                 s0_req,
  input  logic [31:0]          s0_vaddr,
  output logic                 s0_valid,
  output logic [31:0]          s0_paddr,
  output logic                 s0_uncached,
  output logic                 s0_refill,
  output logic                 s0_invalid,

  input  logic                 s1_req,
  input  logic [31:0]          s1_vaddr,
  input  logic                 s1_store,
  output logic                 s1_valid,
  output logic [31:0]          s1_paddr,
  output logic                 s1_uncached,
  output logic                 s1_refill,
  output logic                 s1_invalid,
  output logic                 s1_modified,

  input  logic                 p_req,
  input  logic [31:0]          p_entryhi,
  output logic                 p_valid,
  output logic [31:0]          p_index,

  input  logic                 r_req,
  input  logic [IW-1:0]        r_index,
  output logic                 r_valid,
  output logic [ENTRY_W-1:0]   r_entry,

  input  logic                 w_en,
  input  logic [IW-1:0]        w_index,
  input  logic [ENTRY_W-1:0]   w_entry
);

  logic [TLBNUM-1:0][ENTRY_W-1:0] entries_q;

  logic            s0_hit, s1_hit, p_hit;
  logic [IW-1:0]   s0_idx, s1_idx, p_idx;
  logic [LO_W-1:0] s0_lo, s1_lo, p_lo;

  xlat_t        s0_res_d, s0_res_q;
  xlat_t        s1_res_d, s1_res_q;
  logic [31:0]  p_index_d, p_index_q;
  logic [ENTRY_W-1:0] r_entry_d, r_entry_q;
  logic         s0_vld_q, s1_vld_q, p_vld_q, r_vld_q;

  logic unused_bits;
  assign unused_bits = ^{p_entryhi[12:8], s0_idx, s1_idx, p_lo};

  tlb_match #(.TLBNUM(TLBNUM)) u_match_s0 (
    .vpn2_i    (s0_vaddr[31:13]),
    .asid_i    (cur_asid),
    .odd_i     (s0_vaddr[12]),
    .entries_i (entries_q),
    .hit_o     (s0_hit),
    .index_o   (s0_idx),
    .lo_o      (s0_lo)
  );

  tlb_match #(.TLBNUM(TLBNUM)) u_match_s1 (
    .vpn2_i    (s1_vaddr[31:13]),
    .asid_i    (cur_asid),
    .odd_i     (s1_vaddr[12]),
    .entries_i (entries_q),
    .hit_o     (s1_hit),
    .index_o   (s1_idx),
    .lo_o      (s1_lo)
  );

  tlb_match #(.TLBNUM(TLBNUM)) u_match_p (
    .vpn2_i    (p_entryhi[31:13]),
    .asid_i    (p_entryhi[7:0]),
    .odd_i     (1'b0),
    .entries_i (entries_q),
    .hit_o     (p_hit),
    .index_o   (p_idx),
    .lo_o      (p_lo)
  );

  // Lookups see entries_q, so a same-edge write only affects later requests.
  always_comb begin
    s0_res_d  = translate(s0_vaddr, s0_hit, s0_lo, 1'b0);
    s1_res_d  = translate(s1_vaddr, s1_hit, s1_lo, s1_store);
    p_index_d = p_hit ? 32'(p_idx) : 32'h8000_0000;
    r_entry_d = entries_q[r_index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      s0_vld_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      p_vld_q   <= 1'b0;
      r_vld_q   <= 1'b0;
      s0_res_q  <= '0;
      s1_res_q  <= '0;
      p_index_q <= '0;
      r_entry_q <= '0;
    end else begin
      s0_vld_q <= s0_req;
      s1_vld_q <= s1_req;
      p_vld_q  <= p_req;
      r_vld_q  <= r_req;
      if (w_en)   entries_q[w_index] <= w_entry;
      if (s0_req) s0_res_q  <= s0_res_d;
      if (s1_req) s1_res_q  <= s1_res_d;
      if (p_req)  p_index_q <= p_index_d;
      if (r_req)  r_entry_q <= r_entry_d;
    end
  end

  assign s0_valid    = s0_vld_q;
  assign s0_paddr    = s0_res_q.paddr;
  assign s0_uncached = s0_res_q.uncached;
  assign s0_refill   = s0_res_q.refill;
  assign s0_invalid  = s0_res_q.invalid;

  assign s1_valid    = s1_vld_q;
  assign s1_paddr    = s1_res_q.paddr;
  assign s1_uncached = s1_res_q.uncached;
  assign s1_refill   = s1_res_q.refill;
  assign s1_invalid  = s1_res_q.invalid;
  assign s1_modified = s1_res_q.modified;

  assign p_valid = p_vld_q;
  assign p_index = p_index_q;
  assign r_valid = r_vld_q;
  assign r_entry = r_entry_q;

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: expected results are queued when a request is
// driven and compared when the matching valid pulse appears.
module tb_tlb_unit;

  localparam int IW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cur_asid;
  logic        s0_req, s0_valid, s0_uncached, s0_refill, s0_invalid;
  logic [31:0] s0_vaddr, s0_paddr;
  logic        s1_req, s1_store, s1_valid, s1_uncached, s1_refill, s1_invalid, s1_modified;
  logic [31:0] s1_vaddr, s1_paddr;
  logic        p_req, p_valid;
  logic [31:0] p_entryhi, p_index;
  logic        r_req, r_valid;
  logic [IW-1:0] r_index, w_index;
  logic [77:0] r_entry, w_entry;
  logic        w_en;

  always #5 clk = ~clk;

  tlb_unit dut (
    .clk(clk), .rst(rst), .cur_asid(cur_asid),
    .s0_req(s0_req), .s0_vaddr(s0_vaddr), .s0_valid(s0_valid), .s0_paddr(s0_paddr),
    .s0_uncached(s0_uncached), .s0_refill(s0_refill), .s0_invalid(s0_invalid),
    .s1_req(s1_req), .s1_vaddr(s1_vaddr), .s1_store(s1_store), .s1_valid(s1_valid),
    .s1_paddr(s1_paddr), .s1_uncached(s1_uncached), .s1_refill(s1_refill),
    .s1_invalid(s1_invalid), .s1_modified(s1_modified),
    .p_req(p_req), .p_entryhi(p_entryhi), .p_valid(p_valid), .p_index(p_index),
    .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_entry(r_entry),
    .w_en(w_en), .w_index(w_index), .w_entry(w_entry)
  );

  typedef struct packed {
    logic [31:0] paddr;
    logic        unc;
    logic        refill;
    logic        inval;
    logic        modif;
  } exp_t;

  exp_t        s0_q[$];
  exp_t        s1_q[$];
  logic [31:0] p_q[$];
  logic [77:0] r_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] lo(input logic [19:0] pfn, input logic [2:0] c,
                                     input logic d, input logic v);
    return {pfn, c, d, v};
  endfunction

  function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                     input logic g, input logic [24:0] lo0,
                                     input logic [24:0] lo1);
    return {vpn2, asid, g, lo0, lo1};
  endfunction

  function automatic exp_t ex(input logic [31:0] pa, input logic unc, input logic rf,
                              input logic inv, input logic md);
    exp_t e;
    e.paddr = pa; e.unc = unc; e.refill = rf; e.inval = inv; e.modif = md;
    return e;
  endfunction

  task automatic do_s0(input logic [31:0] va, input exp_t e);
    s0_req = 1'b1; s0_vaddr = va; s0_q.push_back(e);
  endtask

  task automatic do_s1(input logic [31:0] va, input logic st, input exp_t e);
    s1_req = 1'b1; s1_vaddr = va; s1_store = st; s1_q.push_back(e);
  endtask

  task automatic do_p(input logic [31:0] hi, input logic [31:0] e);
    p_req = 1'b1; p_entryhi = hi; p_q.push_back(e);
  endtask

  task automatic do_r(input logic [IW-1:0] idx, input logic [77:0] e);
    r_req = 1'b1; r_index = idx; r_q.push_back(e);
  endtask

  task automatic do_w(input logic [IW-1:0] idx, input logic [77:0] e);
    w_en = 1'b1; w_index = idx; w_entry = e;
  endtask

  task automatic step();
    @(negedge clk);
    s0_req = 1'b0; s1_req = 1'b0; s1_store = 1'b0;
    p_req = 1'b0; r_req = 1'b0; w_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (s0_valid) begin
      if (s0_q.size() == 0) check("s0_spurious", 1, 0);
      else begin
        exp_t e;
        e = s0_q.pop_front();
        check("s0_paddr", s0_paddr, e.paddr);
        check("s0_flags", {s0_uncached, s0_refill, s0_invalid}, {e.unc, e.refill, e.inval});
      end
    end
    if (s1_valid) begin
      if (s1_q.size() == 0) check("s1_spurious", 1, 0);
      else begin
        exp_t e;
        e = s1_q.pop_front();
        check("s1_paddr", s1_paddr, e.paddr);
        check("s1_flags", {s1_uncached, s1_refill, s1_invalid, s1_modified},
              {e.unc, e.refill, e.inval, e.modif});
      end
    end
    if (p_valid) begin
      if (p_q.size() == 0) check("p_spurious", 1, 0);
      else check("p_index", p_index, p_q.pop_front());
    end
    if (r_valid) begin
      if (r_q.size() == 0) check("r_spurious", 1, 0);
      else check("r_entry", r_entry, r_q.pop_front());
    end
  end

  logic [77:0] e1, e1g, e4, e7;

  initial begin
    e1  = mk(19'h00200, 8'h05, 1'b0, lo(20'h01234, 3'd3, 1'b1, 1'b1), lo(20'h0, 3'd0, 1'b0, 1'b0));
    e1g = mk(19'h00200, 8'h05, 1'b1, lo(20'h01234, 3'd3, 1'b1, 1'b1), lo(20'h05678, 3'd3, 1'b1, 1'b0));
    e4  = mk(19'h00300, 8'h06, 1'b0, lo(20'h0AAAA, 3'd3, 1'b0, 1'b1), lo(20'h0BBBB, 3'd2, 1'b1, 1'b1));
    e7  = mk(19'h00300, 8'h00, 1'b1, lo(20'h0CCCC, 3'd3, 1'b1, 1'b1), lo(20'h0, 3'd0, 1'b0, 1'b0));

    rst = 1'b1; cur_asid = 8'h05;
    s0_req = 1'b0; s0_vaddr = '0; s1_req = 1'b0; s1_vaddr = '0; s1_store = 1'b0;
    p_req = 1'b0; p_entryhi = '0; r_req = 1'b0; r_index = '0;
    w_en = 1'b0; w_index = '0; w_entry = '0;
    repeat (3) @(negedge clk);
    check("rst_valids", {s0_valid, s1_valid, p_valid, r_valid}, 4'b0);
    check("rst_s0_paddr", s0_paddr, 32'h0);
    check("rst_p_index", p_index, 32'h0);
    check("rst_r_entry", r_entry, 78'h0);
    check("rst_flags", {s0_uncached, s0_refill, s0_invalid, s1_uncached, s1_refill,
                        s1_invalid, s1_modified}, 7'b0);
    rst = 1'b0;

    // Write index 3 while probing/looking up the same page: both see empty TLB.
    do_s0(32'h0040_0000, ex(32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    do_s1(32'h0040_0ABC, 1'b0, ex(32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    do_p(32'h0040_0005, 32'h8000_0000);
    do_w(4'd3, e1);
    step();
    do_p(32'h0040_0005, 32'h0000_0003);
    do_r(4'd3, e1);
    do_s1(32'h0040_0ABC, 1'b0, ex(32'h0123_4ABC, 1'b0, 1'b0, 1'b0, 1'b0));
    do_s0(32'hA000_1234, ex(32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0));
    step();
    cur_asid = 8'h06;
    do_s1(32'h0040_0ABC, 1'b0, ex(32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    do_s0(32'h8000_1234, ex(32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0));
    do_w(4'd3, e1g);
    step();
    do_s1(32'h0040_0ABC, 1'b0, ex(32'h0123_4ABC, 1'b0, 1'b0, 1'b0, 1'b0));
    do_s0(32'h0040_1000, ex(32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    do_w(4'd4, e4);
    step();
    do_s1(32'h0060_0010, 1'b1, ex(32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    do_s0(32'h0060_1020, ex(32'h0BBB_B020, 1'b1, 1'b0, 1'b0, 1'b0));
    do_w(4'd7, e7);
    step();
    // Entries 4 and 7 both match ASID 6; the lower index must win.
    do_s1(32'h0060_0010, 1'b0, ex(32'h0AAA_A010, 1'b0, 1'b0, 1'b0, 1'b0));
    do_p(32'h0060_0006, 32'h0000_0004);
    do_r(4'd7, e7);
    step();
    cur_asid = 8'h09;
    do_s1(32'h0060_0010, 1'b0, ex(32'h0CCC_C010, 1'b0, 1'b0, 1'b0, 1'b0));
    do_p(32'h0060_0009, 32'h0000_0007);
    do_s0(32'hC000_0000, ex(32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    step();
    step();

    // Reset coincident with a request: no pulse, results and entries cleared.
    rst = 1'b1;
    s0_req = 1'b1; s0_vaddr = 32'h0060_0010;
    @(negedge clk);
    s0_req = 1'b0; rst = 1'b0;
    check("rst_mid_s0_valid", s0_valid, 1'b0);
    check("rst_mid_s1_paddr", s1_paddr, 32'h0);
    check("rst_mid_p_index", p_index, 32'h0);
    do_p(32'h0060_0006, 32'h8000_0000);
    step();
    step();
    step();
    check("queues_drained", s0_q.size() + s1_q.size() + p_q.size() + r_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
